// File: rtl/interp_phase_sequencer.sv
// ---------------------------------------------------------------------------
// interp_phase_sequencer
//
// Interpolation-side rate sequencer for a polyphase filter. Each accepted
// low-rate input sample is held and re-issued as L evenly spaced high-rate
// output strobes, P clocks apart. Each strobe is tagged with its polyphase
// branch index so the downstream MAC can select its coefficient bank.
//
// Parameters:
//   L - interpolation factor (phases per input sample), L >= 2
//   P - clocks between successive output strobes, P >= 2
//   W - sample width
//
// Ports:
//   in_clk     - system clock, all logic on the rising edge
//   rst        - asynchronous active-low reset
//   in_strobe  - one-cycle pulse marking a valid input sample
//   in_data    - input sample, sampled only with in_strobe
//   out_strobe - registered one-cycle pulse per output phase
//   out_phase  - branch index of the current or most recent strobe
//   out_data   - held sample, updated only on accepted strobes
//   busy       - high while a phase sequence is in progress
//   overrun    - sticky: an in_strobe arrived while busy
// ---------------------------------------------------------------------------
module interp_phase_sequencer #(
   parameter  int L  = 4,
   parameter  int P  = 13,
   parameter  int W  = 16,
   localparam int PW = (L > 1) ? $clog2(L) : 1,
   localparam int CW = (P > 1) ? $clog2(P) : 1
) (
   input  logic          in_clk,
   input  logic          rst,
   input  logic          in_strobe,
   input  logic [W-1:0]  in_data,
   output logic          out_strobe,
   output logic [PW-1:0] out_phase,
   output logic [W-1:0]  out_data,
   output logic          busy,
   output logic          overrun
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [PW-1:0] PH_LAST  = PW'(L - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   ph_q, ph_d;
   logic [W-1:0]    data_q, data_d;
   logic            strobe_q, strobe_d;
   logic            ovr_q, ovr_d;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ph_q     <= '0;
         data_q   <= '0;
         strobe_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ph_q     <= ph_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         ovr_q    <= ovr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ph_d     = ph_q;
      data_d   = data_q;
      strobe_d = 1'b0;
      ovr_d    = ovr_q;

      unique case (state_q)
         IDLE: begin
            // Phase 0 is issued on the very next cycle, so the spacing
            // counter starts at zero together with the first strobe.
            if (in_strobe) begin
               state_d  = RUN;
               data_d   = in_data;
               ph_d     = '0;
               cnt_d    = '0;
               strobe_d = 1'b1;
            end
         end

         RUN: begin
            // A sample offered mid-sequence is dropped, not queued.
            if (in_strobe) begin
               ovr_d = 1'b1;
            end
            // The cycle carrying the last phase strobe is the last busy
            // cycle; leaving here lets a strobe arriving right after be
            // accepted, which keeps a L*P input cadence gap-free.
            if (ph_q == PH_LAST) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               ph_d     = ph_q + PW'(1);
               strobe_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign out_strobe = strobe_q;
   assign out_phase  = ph_q;
   assign out_data   = data_q;
   assign busy       = (state_q == RUN);
   assign overrun    = ovr_q;

endmodule
